mem_access_stage: RTL
=====================

# mem_access_stage

Pipeline MEM stage between the EX/MEM register and the MEM/WB register. It turns load/store requests into a req/ack transaction on the data-memory bus. It aligns store data and byte strobes, and extracts and sign/zero-extends load data. It stalls the front of the pipeline while a memory access is outstanding and presents a completed instruction, or a bubble, to the MEM/WB register every cycle.

## Interface
- REG_WIDTH, 64, datapath width; only 64 is supported.
- WB_CTRL_BITS, 5, width of the write-back control bundle passed through.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  EX/MEM holds a valid instruction.
- mem_read_in / mem_write_in  in  1 each  load / store request; both high → mem_exc.
- funct3_in  in  3  access size and signedness (RV64 encoding).
- ALU_res_in  in  REG_WIDTH  effective address or ALU result.
- store_data_in  in  REG_WIDTH  rs2 value for stores.
- WB_Ctrl_in  in  WB_CTRL_BITS  write-back control.
- rd_addr_in  in  $clog2(REG_WIDTH)  destination register.
- WB_Ctrl_out  out  WB_CTRL_BITS  to MEM/WB; 0 = bubble.
- mem_read_data_out  out  REG_WIDTH  extended load data; 0 for non-loads.
- ALU_res_out  out  REG_WIDTH  pass-through address/result.
- rd_addr_out  out  $clog2(REG_WIDTH)  pass-through rd.
- stall_out  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- mem_exc  out  1  one-cycle pulse: misaligned address or illegal funct3.
- dmem_req  out  1  bus request; held until ack.
- dmem_we  out  1  1 = write.
- dmem_addr  out  REG_WIDTH  8-byte-aligned address (ALU_res[2:0] zeroed).
- dmem_wdata  out  REG_WIDTH  lane-aligned store data.
- dmem_wstrb  out  REG_WIDTH/8  byte enables.
- dmem_rdata  in  REG_WIDTH  read data; valid with ack.
- dmem_ack  in  1  transaction complete; ignored unless dmem_req is high.

## Operation
- FSM states: IDLE, REQ, RESP. Reset → IDLE. All registered state and outputs clear to 0: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, latched fields, and load data.
- **IDLE, no memory op** (in_valid=0, or neither read nor write): outputs are a combinational pass-through of the inputs; mem_read_data_out=0; stall_out=0. If in_valid=0, WB_Ctrl_out=0.
- **IDLE, legal memory op**:
  - Latch address, funct3, WB_Ctrl, rd, and we.
  - Compute offset = addr[2:0].
  - Store lanes: dmem_wdata = store_data << 8·offset; dmem_wstrb = size mask (0x01/0x03/0x0F/0xFF) << offset.
  - Loads: dmem_wstrb=0.
  - Next state REQ. Cycle outputs: stall_out=1, WB_Ctrl_out=0.
- **IDLE, illegal memory op**:
  - Illegal means a misaligned address (half: addr[0]≠0; word: addr[1:0]≠0; double: addr[2:0]≠0), read and write both high, load funct3=111, or store funct3≥100.
  - mem_exc=1 for one cycle; no bus request; WB_Ctrl_out=0; stall_out=0. The instruction is squashed.
- **REQ**:
  - dmem_req=1; dmem_we, dmem_addr, dmem_wdata, dmem_wstrb stay constant; stall_out=1; WB_Ctrl_out=0.
  - On dmem_ack: capture dmem_rdata >> 8·offset, then extend per funct3: 000 LB sext8, 001 LH sext16, 010 LW sext32, 011 LD, 100 LBU, 101 LHU, 110 LWU. Next state RESP.
- **RESP**:
  - Outputs come from the latched fields: WB_Ctrl_out = latched WB_Ctrl; mem_read_data_out = extended data for loads, 0 for stores.
  - stall_out=0. EX/MEM advances at the end of this cycle; inputs seen during RESP are ignored. Next state IDLE.
- dmem_ack outside REQ is ignored.
- rst mid-transaction: FSM returns to IDLE, dmem_req drops immediately, and the instruction is lost.

## Timing
- Non-memory op: 0-cycle combinational pass-through; no stall.
- Memory op with ack on the first REQ cycle: stall_out high for 2 cycles (IDLE-detect, REQ); result appears on the outputs in cycle 3 (RESP). Each extra cycle of ack delay adds one stall cycle.
- dmem_req rises on the clock edge after detection and falls on the edge after ack. No back-to-back requests: there is at least one non-REQ cycle (RESP) between transactions.
- stall_out is combinational: (IDLE & in_valid & legal memory op) | REQ.
- mem_exc is combinational in IDLE only.

## Test plan
- Non-memory pass-through: ALU op, ALU_res_in=0x1234, rd=5, WB_Ctrl=0x11 → same values on the outputs in the same cycle, stall_out=0, dmem_req never rises.
- LB: addr=0x1003, dmem_rdata=0x00000000_80000000, ack 1 cycle after req → dmem_addr=0x1000, stall for 2 cycles, mem_read_data_out=0xFFFF_FFFF_FFFF_FF80 in RESP. Same case with LBU → 0x80.
- SH: addr=0x2006, store_data=0xABCD → dmem_wstrb=0xC0, dmem_wdata[63:48]=0xABCD, dmem_we=1, mem_read_data_out=0 in RESP.
- Slow memory: LD with ack delayed 4 cycles → req and address stable throughout, stall_out high for 5 cycles, single RESP; an ack pulse injected while in IDLE is ignored.
- Misaligned LW at addr=0x3002 → mem_exc pulses once, no dmem_req, WB_Ctrl_out=0, stall_out=0.
- Reset asserted in REQ → dmem_req=0 and all outputs 0 immediately; the next load after reset completes normally.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// The master holds dmem_req and the payload until dmem_ack completes the transaction.
interface mem_access_stage_if #(
  parameter int REG_WIDTH = 64
);
  logic                   dmem_req;
  logic                   dmem_we;
  logic [REG_WIDTH-1:0]   dmem_addr;
  logic [REG_WIDTH-1:0]   dmem_wdata;
  logic [REG_WIDTH/8-1:0] dmem_wstrb;
  logic [REG_WIDTH-1:0]   dmem_rdata;
  logic                   dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: turns loads/stores into req/ack bus transactions, aligns
// store lanes, extends load data and stalls the front end while a request is open.
module mem_access_stage #(
  parameter int REG_WIDTH    = 64,
  parameter int WB_CTRL_BITS = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic                         mem_read_in,
  input  logic                         mem_write_in,
  input  logic [2:0]                   funct3_in,
  input  logic [REG_WIDTH-1:0]         ALU_res_in,
  input  logic [REG_WIDTH-1:0]         store_data_in,
  input  logic [WB_CTRL_BITS-1:0]      WB_Ctrl_in,
  input  logic [$clog2(REG_WIDTH)-1:0] rd_addr_in,
  output logic [WB_CTRL_BITS-1:0]      WB_Ctrl_out,
  output logic [REG_WIDTH-1:0]         mem_read_data_out,
  output logic [REG_WIDTH-1:0]         ALU_res_out,
  output logic [$clog2(REG_WIDTH)-1:0] rd_addr_out,
  output logic                         stall_out,
  output logic                         mem_exc,
  mem_access_stage_if.master           dmem
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                       state_reg, state_next;
  logic [REG_WIDTH-1:0]         addr_reg, addr_next;
  logic [2:0]                   funct3_reg, funct3_next;
  logic [WB_CTRL_BITS-1:0]      wb_ctrl_reg, wb_ctrl_next;
  logic [$clog2(REG_WIDTH)-1:0] rd_reg, rd_next;
  logic                         we_reg, we_next;
  logic [REG_WIDTH-1:0]         wdata_reg, wdata_next;
  logic [REG_WIDTH/8-1:0]       wstrb_reg, wstrb_next;
  logic [REG_WIDTH-1:0]         load_data_reg, load_data_next;

  logic [2:0]             offset;
  logic                   mem_op, misaligned, bad_funct3, illegal;
  logic [7:0]             size_mask;
  logic [REG_WIDTH-1:0]   rdata_shifted, rdata_ext;

  // Request decode on the incoming EX/MEM contents
  always_comb begin
    offset     = ALU_res_in[2:0];
    mem_op     = in_valid & (mem_read_in | mem_write_in);
    bad_funct3 = (mem_read_in && funct3_in == 3'b111) || (mem_write_in && funct3_in[2]);
    misaligned = 1'b0;
    size_mask  = 8'h01;
    case (funct3_in[1:0])
      2'b01: begin misaligned = offset[0];      size_mask = 8'h03; end
      2'b10: begin misaligned = |offset[1:0];   size_mask = 8'h0F; end
      2'b11: begin misaligned = |offset;        size_mask = 8'hFF; end
      default: begin misaligned = 1'b0;         size_mask = 8'h01; end
    endcase
    illegal = misaligned | (mem_read_in & mem_write_in) | bad_funct3;
  end

  // Load lane extraction uses the offset latched with the request
  always_comb begin
    rdata_shifted = dmem.dmem_rdata >> {addr_reg[2:0], 3'b000};
    case (funct3_reg)
      3'b000:  rdata_ext = {{(REG_WIDTH-8){rdata_shifted[7]}},   rdata_shifted[7:0]};
      3'b001:  rdata_ext = {{(REG_WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      3'b010:  rdata_ext = {{(REG_WIDTH-32){rdata_shifted[31]}}, rdata_shifted[31:0]};
      3'b100:  rdata_ext = {{(REG_WIDTH-8){1'b0}},               rdata_shifted[7:0]};
      3'b101:  rdata_ext = {{(REG_WIDTH-16){1'b0}},              rdata_shifted[15:0]};
      3'b110:  rdata_ext = {{(REG_WIDTH-32){1'b0}},              rdata_shifted[31:0]};
      default: rdata_ext = rdata_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      funct3_reg    <= '0;
      wb_ctrl_reg   <= '0;
      rd_reg        <= '0;
      we_reg        <= 1'b0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      load_data_reg <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      funct3_reg    <= funct3_next;
      wb_ctrl_reg   <= wb_ctrl_next;
      rd_reg        <= rd_next;
      we_reg        <= we_next;
      wdata_reg     <= wdata_next;
      wstrb_reg     <= wstrb_next;
      load_data_reg <= load_data_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    addr_next         = addr_reg;
    funct3_next       = funct3_reg;
    wb_ctrl_next      = wb_ctrl_reg;
    rd_next           = rd_reg;
    we_next           = we_reg;
    wdata_next        = wdata_reg;
    wstrb_next        = wstrb_reg;
    load_data_next    = load_data_reg;
    stall_out         = 1'b0;
    mem_exc           = 1'b0;
    WB_Ctrl_out       = '0;
    mem_read_data_out = '0;
    ALU_res_out       = ALU_res_in;
    rd_addr_out       = rd_addr_in;

    case (state_reg)
      IDLE: begin
        if (!mem_op) begin
          WB_Ctrl_out = in_valid ? WB_Ctrl_in : '0;
        end else if (illegal) begin
          mem_exc = 1'b1;
        end else begin
          stall_out    = 1'b1;
          addr_next    = ALU_res_in;
          funct3_next  = funct3_in;
          wb_ctrl_next = WB_Ctrl_in;
          rd_next      = rd_addr_in;
          we_next      = mem_write_in;
          wdata_next   = mem_write_in ? (store_data_in << {offset, 3'b000}) : '0;
          wstrb_next   = mem_write_in ? (size_mask << offset) : '0;
          state_next   = REQ;
        end
      end
      REQ: begin
        stall_out   = 1'b1;
        ALU_res_out = addr_reg;
        rd_addr_out = rd_reg;
        if (dmem.dmem_ack) begin
          load_data_next = rdata_ext;
          state_next     = RESP;
        end
      end
      RESP: begin
        WB_Ctrl_out       = wb_ctrl_reg;
        ALU_res_out       = addr_reg;
        rd_addr_out       = rd_reg;
        mem_read_data_out = we_reg ? '0 : load_data_reg;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // Reset blanks every output at once, including the combinational pass-through
    if (rst) begin
      stall_out         = 1'b0;
      mem_exc           = 1'b0;
      WB_Ctrl_out       = '0;
      mem_read_data_out = '0;
      ALU_res_out       = '0;
      rd_addr_out       = '0;
    end
  end

  assign dmem.dmem_req   = (state_reg == REQ);
  assign dmem.dmem_we    = we_reg;
  assign dmem.dmem_addr  = {addr_reg[REG_WIDTH-1:3], 3'b000};
  assign dmem.dmem_wdata = wdata_reg;
  assign dmem.dmem_wstrb = wstrb_reg;

endmodule
